step_dir_rx: RTL and testbench
==============================

// Module: step_dir_rx
// PURPOSE
// - Receive end of the step/dir motor interface: decodes external STEP/DIR/EN pins into a signed position.
// - Also measures step period, detects motion/stall, flags a reached target and latches pin faults.
// - Used for loop-back verification of the step generator and as position feedback from external indexers.
// - Sits between FPGA input pins and the AXI register block; all outputs are register-level.
// PARAMETERS
// SYNC_STAGES  2            flip-flop stages on each async pin (>=2)
// MIN_PULSE    4            consecutive synced samples required to accept a STEP level change (>=1)
// TIMEOUT      100_000_000  clocks without an accepted edge before motion is declared stopped
// PORTS
// i_clk            in   1   system clock
// i_fRST           in   1   reset, asynchronous, active-high
// i_step           in   1   STEP pin, async; rising edge = one step
// i_dir            in   1   DIR pin, async; 1 = +1, 0 = -1
// i_en             in   1   ENABLE pin, async; 1 = counting enabled
// i_clr            in   1   sync pulse: clear position, count, faults, reached
// i_target         in   32  signed target position
// i_target_vld     in   1   sync pulse: latch i_target and arm the compare
// o_pos            out  32  signed position
// o_step_cnt       out  32  unsigned accepted steps since clear
// o_period         out  32  clocks between the last two accepted rising edges
// o_period_vld     out  1   1-cycle strobe when o_period updates
// o_moving         out  1   1 while edges arrive within TIMEOUT
// o_reached        out  1   sticky: armed target matched
// o_fault_glitch   out  1   sticky: STEP pulse shorter than MIN_PULSE
// o_fault_dir      out  1   sticky: DIR changed during STEP rise qualification
// BEHAVIOUR
// - Reset: all outputs 0; filter in S_LOW; armed=0; period counter 0; first-edge flag clear.
// - STEP/DIR/EN each pass through SYNC_STAGES FFs; all logic below uses the synced values.
// - STEP filter FSM (qcnt counts consecutive samples of the new level):
//   - S_LOW: synced STEP=1 -> S_RISE, qcnt=1.
//   - S_RISE: STEP=1 and qcnt==MIN_PULSE -> S_HIGH and accept edge.
//     STEP=1 otherwise qcnt++. STEP=0 -> S_LOW and set o_fault_glitch.
//   - S_HIGH: STEP=0 -> S_FALL, qcnt=1.
//   - S_FALL: STEP=0 and qcnt==MIN_PULSE -> S_LOW. STEP=1 before that -> S_HIGH and set o_fault_glitch.
//   - MIN_PULSE=1: S_RISE/S_FALL accept on their first cycle.
// - Latency: pin rise to o_pos/o_step_cnt update = SYNC_STAGES+MIN_PULSE+1 clocks.
// - Accepted edge with EN=1:
//   - o_pos += (DIR ? +1 : -1), DIR taken at acceptance; two's-complement wrap, 0x7FFFFFFF+1 = 0x80000000.
//   - o_step_cnt += 1, wraps at 2^32.
// - Accepted edge with EN=0: no count change, no period strobe; period counter and first-edge flag cleared.
// - Period counter pcnt: +1 each clock, saturates at TIMEOUT. On accepted edge with EN=1:
//   - first-edge flag set: o_period<=pcnt and o_period_vld=1 for one cycle.
//   - in all cases pcnt<=1 and first-edge flag set.
//   - pcnt reaching TIMEOUT clears o_moving and the first-edge flag; the next edge gives no period.
// - o_moving: set on accepted EN=1 edge, cleared at TIMEOUT or i_clr.
// - Target: i_target_vld latches target and sets armed. While armed, o_pos==target sets o_reached and clears armed.
//   - o_reached is asserted 1 cycle after the equality is visible.
//   - Arming when o_pos already equals target sets o_reached 2 cycles after i_target_vld.
//   - i_target_vld clears o_reached.
// - o_fault_dir: set if synced DIR changes on any cycle while FSM is in S_RISE.
// - i_clr: o_pos, o_step_cnt, o_reached, both faults, o_moving, pcnt and first-edge flag go to 0. Armed is kept.
// - Priority: i_clr beats a same-cycle accepted edge (edge dropped, pos=0).
//   - i_clr + i_target_vld in the same cycle: both apply; target is compared against 0.
// - i_fRST mid-pulse: FSM returns to S_LOW. A STEP still high after reset release qualifies as a new rising edge.
// TESTING
// - Reset, EN=1, DIR=1, 10 STEP pulses 8clk hi/8clk lo -> o_pos=10, o_step_cnt=10, o_period=16, o_moving=1.
// - DIR=0, 3 pulses from pos 0 -> o_pos=-3 (0xFFFFFFFD); one edge at pos 0x7FFFFFFF with DIR=1 -> 0x80000000.
// - 2-clk STEP pulse, MIN_PULSE=4 -> no count, o_fault_glitch=1; i_clr -> fault 0.
// - Arm target=5 at pos 0, send 5 steps -> o_reached=1 exactly SYNC_STAGES+MIN_PULSE+2 clocks after 5th rise.
// - Stop pulses, TIMEOUT=1000 -> o_moving falls 1000 clocks after last accepted edge; next edge gives no o_period_vld.
// - i_clr coincident with an accepted edge -> o_pos=0, o_step_cnt=0. EN=0 pulses -> counts unchanged.

Source files
------------

// File: rtl/step_dir_rx.sv
// Step/dir receiver: synchronises STEP/DIR/EN pins, filters STEP, and turns accepted
// rising edges into position, step count, period, motion, target and fault status.
module step_dir_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_PULSE   = 4,
    parameter int TIMEOUT     = 100_000_000
) (
    input  logic        i_clk,
    input  logic        i_fRST,
    input  logic        i_step,
    input  logic        i_dir,
    input  logic        i_en,
    input  logic        i_clr,
    input  logic [31:0] i_target,
    input  logic        i_target_vld,
    output logic [31:0] o_pos,
    output logic [31:0] o_step_cnt,
    output logic [31:0] o_period,
    output logic        o_period_vld,
    output logic        o_moving,
    output logic        o_reached,
    output logic        o_fault_glitch,
    output logic        o_fault_dir
);
    localparam int          QW   = (MIN_PULSE < 1) ? 1 : $clog2(MIN_PULSE + 1);
    localparam logic [QW-1:0] QMAX = QW'(MIN_PULSE);
    localparam logic [31:0] TO   = 32'(TIMEOUT);

    typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_t;

    // Bit order per stage: {step, dir, en}
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic                        step_s, dir_s, en_s, dir_d;

    state_t      state;
    logic [QW-1:0] qcnt;
    logic [31:0] pcnt;
    logic [31:0] target;
    logic        armed;
    logic        first;
    logic        accept;
    logic        glitch_ev;

    assign step_s    = sync_q[SYNC_STAGES-1][2];
    assign dir_s     = sync_q[SYNC_STAGES-1][1];
    assign en_s      = sync_q[SYNC_STAGES-1][0];
    assign accept    = (state == S_RISE) && step_s && (qcnt == QMAX);
    assign glitch_ev = ((state == S_RISE) && !step_s) || ((state == S_FALL) && step_s);

    always_ff @(posedge i_clk or posedge i_fRST) begin
        if (i_fRST) begin
            sync_q <= '0;
            dir_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {i_step, i_dir, i_en}};
            dir_d  <= dir_s;
        end
    end

    // STEP qualification filter; independent of i_clr
    always_ff @(posedge i_clk or posedge i_fRST) begin
        if (i_fRST) begin
            state <= S_LOW;
            qcnt  <= '0;
        end else begin
            case (state)
                S_LOW:  if (step_s) begin state <= S_RISE; qcnt <= QW'(1); end
                S_RISE: if (!step_s)        state <= S_LOW;
                        else if (accept)    state <= S_HIGH;
                        else                qcnt  <= qcnt + 1'b1;
                S_HIGH: if (!step_s) begin state <= S_FALL; qcnt <= QW'(1); end
                S_FALL: if (step_s)                 state <= S_HIGH;
                        else if (qcnt == QMAX)      state <= S_LOW;
                        else                        qcnt  <= qcnt + 1'b1;
                default: state <= S_LOW;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_fRST) begin
        if (i_fRST) begin
            o_pos          <= '0;
            o_step_cnt     <= '0;
            o_period       <= '0;
            o_period_vld   <= 1'b0;
            o_moving       <= 1'b0;
            o_reached      <= 1'b0;
            o_fault_glitch <= 1'b0;
            o_fault_dir    <= 1'b0;
            pcnt           <= '0;
            first          <= 1'b0;
            target         <= '0;
            armed          <= 1'b0;
        end else begin
            o_period_vld <= 1'b0;
            if (i_clr) begin
                o_pos          <= '0;
                o_step_cnt     <= '0;
                o_reached      <= 1'b0;
                o_fault_glitch <= 1'b0;
                o_fault_dir    <= 1'b0;
                o_moving       <= 1'b0;
                pcnt           <= '0;
                first          <= 1'b0;
            end else begin
                if (pcnt != TO) pcnt <= pcnt + 32'd1;
                if (pcnt == TO) begin
                    o_moving <= 1'b0;
                    first    <= 1'b0;
                end
                if (accept) begin
                    if (en_s) begin
                        o_pos      <= dir_s ? o_pos + 32'd1 : o_pos - 32'd1;
                        o_step_cnt <= o_step_cnt + 32'd1;
                        o_moving   <= 1'b1;
                        if (first) begin
                            o_period     <= pcnt;
                            o_period_vld <= 1'b1;
                        end
                        pcnt  <= 32'd1;
                        first <= 1'b1;
                    end else begin
                        // Disabled edges break the period chain
                        pcnt  <= '0;
                        first <= 1'b0;
                    end
                end
                if (glitch_ev)                             o_fault_glitch <= 1'b1;
                if ((state == S_RISE) && (dir_s != dir_d)) o_fault_dir    <= 1'b1;
                if (armed && (o_pos == target)) begin
                    o_reached <= 1'b1;
                    armed     <= 1'b0;
                end
            end
            // Re-arming wins over a same-cycle compare and restarts the reached flag
            if (i_target_vld) begin
                target    <= i_target;
                armed     <= 1'b1;
                o_reached <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_step_dir_rx.sv
// Directed bench for step_dir_rx: SYNC_STAGES=2, MIN_PULSE=4, TIMEOUT=1000.
module tb_step_dir_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step = 1'b0, dir = 1'b0, en = 1'b0, clr = 1'b0, tvld = 1'b0;
    logic [31:0] target = '0;
    logic [31:0] pos, step_cnt, period;
    logic        period_vld, moving, reached, fault_glitch, fault_dir;

    int tests = 0;
    int fails = 0;
    int vld_cnt = 0;
    int base;

    step_dir_rx #(.SYNC_STAGES(2), .MIN_PULSE(4), .TIMEOUT(1000)) dut (
        .i_clk(clk), .i_fRST(rst), .i_step(step), .i_dir(dir), .i_en(en), .i_clr(clr),
        .i_target(target), .i_target_vld(tvld),
        .o_pos(pos), .o_step_cnt(step_cnt), .o_period(period), .o_period_vld(period_vld),
        .o_moving(moving), .o_reached(reached), .o_fault_glitch(fault_glitch),
        .o_fault_dir(fault_dir)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (period_vld) vld_cnt <= vld_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        step = 1'b1; cyc(hi);
        step = 1'b0; cyc(lo);
    endtask

    task automatic do_clr();
        clr = 1'b1; cyc(1);
        clr = 1'b0;
    endtask

    initial begin
        cyc(3);
        check("reset_pos", pos, 0);
        check("reset_cnt", step_cnt, 0);
        check("reset_period", period, 0);
        check("reset_flags", {26'd0, period_vld, moving, reached, fault_glitch, fault_dir}, 0);
        rst = 1'b0;

        // 10 pulses 8 hi / 8 lo, counting up
        en = 1'b1; dir = 1'b1; cyc(4);
        base = vld_cnt;
        repeat (10) pulse(8, 8);
        check("up_pos", pos, 10);
        check("up_cnt", step_cnt, 10);
        check("up_period", period, 16);
        check("up_moving", moving, 1);
        check("up_vld_strobes", vld_cnt - base, 9);
        check("up_no_glitch", fault_glitch, 0);

        // Clear, then 3 pulses downward
        do_clr();
        check("clr_pos", pos, 0);
        check("clr_cnt", step_cnt, 0);
        check("clr_moving", moving, 0);
        dir = 1'b0; cyc(3);
        repeat (3) pulse(8, 8);
        check("down_pos", pos, 32'hFFFF_FFFD);
        check("down_cnt", step_cnt, 3);
        check("down_no_dirfault", fault_dir, 0);

        // Short pulse rejected as glitch
        pulse(2, 10);
        check("glitch_cnt", step_cnt, 3);
        check("glitch_flag", fault_glitch, 1);
        do_clr();
        check("glitch_clr", fault_glitch, 0);
        check("glitch_clr_cnt", step_cnt, 0);

        // DIR change while rise is being qualified; DIR at acceptance is 1
        step = 1'b1; cyc(3);
        dir = 1'b1; cyc(13);
        step = 1'b0; cyc(8);
        check("dirfault_flag", fault_dir, 1);
        check("dirfault_pos", pos, 1);
        do_clr();
        check("dirfault_clr", fault_dir, 0);

        // Arm target 5 at pos 0, then check exact reached timing on the 5th rise
        target = 32'd5; tvld = 1'b1; cyc(1);
        tvld = 1'b0;
        check("arm_reached0", reached, 0);
        repeat (4) pulse(8, 8);
        step = 1'b1; cyc(6);
        check("tgt_pos_before", pos, 4);
        cyc(1);
        check("tgt_pos_latency", pos, 5);
        check("tgt_not_yet", reached, 0);
        cyc(1);
        check("tgt_reached", reached, 1);
        step = 1'b0; cyc(8);

        // Arming when already equal: cleared then set 2 cycles after the pulse
        tvld = 1'b1; cyc(1);
        tvld = 1'b0;
        check("rearm_cleared", reached, 0);
        cyc(1);
        check("rearm_reached", reached, 1);

        // Timeout: moving drops 1000 clocks after the accepted edge
        step = 1'b1; cyc(7);
        check("to_pos", pos, 6);
        cyc(1);
        step = 1'b0; cyc(998);
        check("to_still_moving", moving, 1);
        cyc(1);
        check("to_stopped", moving, 0);
        base = vld_cnt;
        pulse(8, 8);
        check("to_no_period", vld_cnt - base, 0);
        check("to_moving_again", moving, 1);
        check("to_pos2", pos, 7);

        // Clear coincident with the accepting clock edge drops the edge
        step = 1'b1; cyc(6);
        clr = 1'b1; cyc(1);
        clr = 1'b0;
        check("clr_edge_pos", pos, 0);
        check("clr_edge_cnt", step_cnt, 0);
        cyc(1);
        step = 1'b0; cyc(8);
        check("clr_edge_pos_after", pos, 0);

        // EN=0: counts unchanged, period chain broken
        en = 1'b0; cyc(3);
        base = vld_cnt;
        repeat (3) pulse(8, 8);
        check("en0_pos", pos, 0);
        check("en0_cnt", step_cnt, 0);
        en = 1'b1; cyc(3);
        pulse(8, 8);
        check("en1_pos", pos, 1);
        check("en1_first_no_vld", vld_cnt - base, 0);
        pulse(8, 8);
        check("en1_period", period, 16);
        check("en1_vld", vld_cnt - base, 1);

        // Reset in mid-pulse; STEP still high requalifies as a new edge
        step = 1'b1; cyc(4);
        rst = 1'b1; cyc(1);
        rst = 1'b0;
        check("rst_mid_pos", pos, 0);
        cyc(6);
        check("rst_mid_pending", pos, 0);
        cyc(1);
        check("rst_mid_new_edge", pos, 1);
        step = 1'b0; cyc(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
